div_seq_ctrl: RTL and testbench

DIV_SEQ_CTRL -- requirements
Module: div_seq_ctrl

---
 rtl/div_seq_ctrl.sv | 168 ++++++++++++++++
 tb/tb_div_seq_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/div_seq_ctrl.sv
// Sequencing controller for a multicycle unsigned divider: operand sign stripping, special cases, result sign fixup.
// Optional macro DIV_SEQ_FASTPATH_EN lets divide-by-zero and signed-overflow requests finish without waiting on the divider.
module div_seq_ctrl #(
    parameter int WIDTH = 32,
    parameter int LAT   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs1,
    input  logic [WIDTH-1:0] rs2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] div_num,
    output logic [WIDTH-1:0] div_denm,
    output logic             div_sn,
    input  logic [WIDTH-1:0] div_quo,
    input  logic [WIDTH-1:0] div_rem
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0]       LAST_CNT = 4'(LAT - 1);
    localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONES     = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] val);
        return ZERO - val;
    endfunction

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] val, input logic is_signed);
        logic [WIDTH-1:0] mag;
        if (is_signed && val[WIDTH-1]) begin
            mag = negate(val);
        end else begin
            mag = val;
        end
        return mag;
    endfunction

    // Architectural answers that never consult the divider
    function automatic logic [WIDTH-1:0] special_result(input logic want_rem, input logic by_zero,
                                                        input logic [WIDTH-1:0] dividend);
        logic [WIDTH-1:0] res;
        if (by_zero) begin
            res = want_rem ? dividend : ONES;
        end else begin
            res = want_rem ? ZERO : dividend;
        end
        return res;
    endfunction

    state_t           state_r;
    logic [3:0]       cnt_r;
    logic             want_rem_r;
    logic             signed_r;
    logic             q_neg_r;
    logic             r_neg_r;
    logic             by_zero_r;
    logic             overflow_r;
    logic [WIDTH-1:0] rs1_r;

    logic             signed_s;
    logic             by_zero_s;
    logic             overflow_s;
    logic [WIDTH-1:0] quo_fix_s;
    logic [WIDTH-1:0] rem_fix_s;
    logic [WIDTH-1:0] calc_result_s;

    assign div_sn = 1'b0;

    // Classify the incoming request from the raw operands
    always_comb begin
        signed_s   = ~op[0];
        by_zero_s  = (rs2 == ZERO);
        overflow_s = signed_s && (rs1 == MOST_NEG) && (rs2 == ONES);
    end

    // Restore signs on the unsigned divider outputs, or substitute the special-case answer
    always_comb begin
        quo_fix_s = (signed_r && q_neg_r) ? negate(div_quo) : div_quo;
        rem_fix_s = (signed_r && r_neg_r) ? negate(div_rem) : div_rem;
        if (by_zero_r || overflow_r) begin
            calc_result_s = special_result(want_rem_r, by_zero_r, rs1_r);
        end else if (want_rem_r) begin
            calc_result_s = rem_fix_s;
        end else begin
            calc_result_s = quo_fix_s;
        end
    end

    // Control FSM with all outputs registered; DONE accepts a new request for back-to-back issue
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            cnt_r      <= 4'd0;
            want_rem_r <= 1'b0;
            signed_r   <= 1'b0;
            q_neg_r    <= 1'b0;
            r_neg_r    <= 1'b0;
            by_zero_r  <= 1'b0;
            overflow_r <= 1'b0;
            rs1_r      <= ZERO;
            busy       <= 1'b0;
            done       <= 1'b0;
            result     <= ZERO;
            div_num    <= ZERO;
            div_denm   <= ZERO;
        end else begin
            done <= 1'b0;
            case (state_r)
                IDLE, DONE: begin
                    if (start) begin
                        want_rem_r <= op[1];
                        signed_r   <= signed_s;
                        q_neg_r    <= rs1[WIDTH-1] ^ rs2[WIDTH-1];
                        r_neg_r    <= rs1[WIDTH-1];
                        by_zero_r  <= by_zero_s;
                        overflow_r <= overflow_s;
                        rs1_r      <= rs1;
                        div_num    <= magnitude(rs1, signed_s);
                        div_denm   <= magnitude(rs2, signed_s);
                        cnt_r      <= 4'd0;
`ifdef DIV_SEQ_FASTPATH_EN
                        if (by_zero_s || overflow_s) begin
                            state_r <= DONE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            result  <= special_result(op[1], by_zero_s, rs1);
                        end else begin
                            state_r <= CALC;
                            busy    <= 1'b1;
                        end
`else
                        state_r <= CALC;
                        busy    <= 1'b1;
`endif
                    end else begin
                        state_r <= IDLE;
                        busy    <= 1'b0;
                    end
                end
                CALC: begin
                    if (cnt_r == LAST_CNT) begin
                        state_r <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        result  <= calc_result_s;
                    end else begin
                        cnt_r <= cnt_r + 4'd1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Self-checking bench for div_seq_ctrl: directed corner cases plus randomized operations
// checked against a plain-arithmetic reference; an ideal divider stub sits on the datapath ports.
module tb_div_seq_ctrl;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [31:0] div_num;
    logic [31:0] div_denm;
    logic        div_sn;
    logic [31:0] div_quo;
    logic [31:0] div_rem;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef DIV_SEQ_FASTPATH_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    div_seq_ctrl #(.WIDTH(32), .LAT(LAT)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .rs1(rs1), .rs2(rs2),
        .busy(busy), .done(done), .result(result),
        .div_num(div_num), .div_denm(div_denm), .div_sn(div_sn),
        .div_quo(div_quo), .div_rem(div_rem)
    );

    always #5 clk = ~clk;

    // Ideal unsigned divider; junk on zero divisor so special cases must not depend on it
    assign div_quo = (div_denm == 32'd0) ? 32'hA5A5_A5A5 : div_num / div_denm;
    assign div_rem = (div_denm == 32'd0) ? 32'h5A5A_5A5A : div_num % div_denm;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // RISC-V style division semantics computed with 64-bit integer arithmetic
    function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) begin
            return o[1] ? a : 32'hFFFF_FFFF;
        end
        if (o[0]) begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end
        q = sa / sb;
        r = sa % sb;
        return o[1] ? r[31:0] : q[31:0];
    endfunction

    function automatic bit is_special(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        return (b == 32'd0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    function automatic logic [31:0] abs_of(input logic [1:0] o, input logic [31:0] v);
        return (!o[0] && v[31]) ? (32'd0 - v) : v;
    endfunction

    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] exp_res;
        int          exp_k;
        int          k;
        int          unstable;
        exp_res  = ref_div(o, a, b);
        exp_k    = (FAST && is_special(o, a, b)) ? 1 : LAT + 1;
        unstable = 0;
        @(negedge clk);
        start = 1'b1; op = o; rs1 = a; rs2 = b;
        @(negedge clk);
        start = 1'b0;
        op    = 2'($urandom_range(0, 3));
        rs1   = $urandom;
        rs2   = $urandom;
        k     = 1;
        if (exp_k > 1) begin
            check({tag, "_busy"}, {31'd0, busy}, 32'd1);
            check({tag, "_num"}, div_num, abs_of(o, a));
            check({tag, "_denm"}, div_denm, abs_of(o, b));
        end
        while (done !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
            if (busy === 1'b1 && (div_num !== abs_of(o, a) || div_denm !== abs_of(o, b))) unstable++;
        end
        check({tag, "_latency"}, 32'(k), 32'(exp_k));
        check({tag, "_result"}, result, exp_res);
        check({tag, "_stable"}, 32'(unstable), 32'd0);
        @(negedge clk);
        check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
        check({tag, "_hold"}, result, exp_res);
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra, rb, exp_res;
        int          n_done, seen;

        rst = 1'b1; start = 1'b0; op = 2'd0; rs1 = 32'd0; rs2 = 32'd0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_num", div_num, 32'd0);
        check("rst_denm", div_denm, 32'd0);
        check("div_sn", {31'd0, div_sn}, 32'd0);
        rst = 1'b0;

        run_op("div_neg7_2", 2'b00, 32'hFFFF_FFF9, 32'd2);
        check("div_neg7_2_val", result, 32'hFFFF_FFFD);
        run_op("rem_neg7_2", 2'b10, 32'hFFFF_FFF9, 32'd2);
        check("rem_neg7_2_val", result, 32'hFFFF_FFFF);
        run_op("divu_big_2", 2'b01, 32'hFFFF_FFF9, 32'd2);
        check("divu_big_2_val", result, 32'h7FFF_FFFC);
        run_op("remu_big_2", 2'b11, 32'hFFFF_FFF9, 32'd2);
        check("remu_big_2_val", result, 32'h0000_0001);
        run_op("div_by0", 2'b00, 32'd5, 32'd0);
        check("div_by0_val", result, 32'hFFFF_FFFF);
        run_op("rem_by0", 2'b10, 32'd5, 32'd0);
        check("rem_by0_val", result, 32'h0000_0005);
        run_op("divu_by0", 2'b01, 32'h8000_0001, 32'd0);
        run_op("rem_by0_neg", 2'b10, 32'hFFFF_FF00, 32'd0);
        run_op("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
        check("div_ovf_val", result, 32'h8000_0000);
        run_op("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        check("rem_ovf_val", result, 32'h0000_0000);
        run_op("divu_ovf_pat", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("div_pos_neg", 2'b00, 32'd100, 32'hFFFF_FFFD);

        // Reset during CALC aborts with no done pulse; previous result is nonzero here
        @(negedge clk);
        start = 1'b1; op = 2'b00; rs1 = 32'd100; rs2 = 32'd3;
        @(negedge clk);
        start = 1'b0;
        check("abort_busy_before", {31'd0, busy}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_result", result, 32'd0);
        check("abort_num", div_num, 32'd0);
        seen = 0;
        repeat (2 * LAT + 4) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        check("abort_no_done", 32'(seen), 32'd0);

        // Reset dominates a simultaneous start (a special case would otherwise finish fastest)
        @(negedge clk);
        rst = 1'b1; start = 1'b1; op = 2'b00; rs1 = 32'd5; rs2 = 32'd0;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        check("rst_start_busy", {31'd0, busy}, 32'd0);
        check("rst_start_done", {31'd0, done}, 32'd0);
        seen = 0;
        repeat (2 * LAT + 4) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        check("rst_start_no_done", 32'(seen), 32'd0);

        // Start held high: accepted every LAT+1 cycles, inputs during busy are junk and ignored
        ro = 2'b00; ra = 32'd1000; rb = 32'd7;
        exp_res = ref_div(ro, ra, rb);
        n_done = 0;
        @(negedge clk);
        start = 1'b1; op = ro; rs1 = ra; rs2 = rb;
        for (int c = 1; c <= 3 * (LAT + 1); c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                n_done++;
                check("b2b_result", result, exp_res);
                check("b2b_cycle", 32'(c), 32'(n_done * (LAT + 1)));
            end
            if (busy === 1'b1) begin
                op  = 2'($urandom_range(0, 3));
                rs1 = $urandom;
            end else begin
                op  = ro;
                rs1 = ra;
            end
        end
        start = 1'b0;
        check("b2b_count", 32'(n_done), 32'd3);
        repeat (LAT + 3) @(negedge clk);

        // Randomized operations with biased corner-case injection
        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 9))
                0:       rb = 32'd0;
                1:       begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2:       rb = 32'($urandom_range(1, 15));
                3:       rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 7));
                4:       ra = 32'($urandom_range(0, 100));
                default: ;
            endcase
            run_op("rand", ro, ra, rb);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
